phy_rx_lane_assembler: RTL and testbench

PHY_RX_LANE_ASSEMBLER -- requirements
Module: phy_rx_lane_assembler

---
 rtl/chiplet_types_pkg.sv | 7 +
 rtl/phy_types_pkg.sv | 15 +
 rtl/phy_rx_crc16.sv | 29 ++
 rtl/phy_rx_lane_assembler.sv | 212 +++++++++++++++++++++
 tb/tb_phy_rx_lane_assembler.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chiplet_types_pkg.sv
// chiplet_types_pkg: types shared across the chiplet fabric.
package chiplet_types_pkg;

    // One 32-bit fabric flit; byte 0 sits in bits [7:0].
    typedef logic [31:0] flit_t;

endpackage

// File: rtl/phy_types_pkg.sv
// phy_types_pkg: PHY receive-side control characters, CRC constants and FSM states.
package phy_types_pkg;

    localparam logic [7:0]  K_SOP    = 8'hBC;
    localparam logic [7:0]  K_EOP    = 8'h3C;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ASSM = 2'd1,
        DROP = 2'd2
    } rx_state_t;

endpackage

// File: rtl/phy_rx_crc16.sv
// phy_rx_crc16: one byte of CRC-16-CCITT (MSB first), purely combinational so
// several instances can be chained to fold a whole flit in one cycle.
module phy_rx_crc16
    import phy_types_pkg::*;
(
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    input  logic [15:0] crc_in,
    output logic [15:0] crc
);
    logic [15:0] c;
    logic        fb;

    // Shift the byte through the LFSR one bit at a time, MSB first.
    always_comb begin
        // NOTE: blocking assignments here on purpose; each loop pass must see the previous pass's value.
        c  = init ? CRC_INIT : crc_in;
        fb = 1'b0;
        if (en) begin
            for (int i = 7; i >= 0; i--) begin
                fb = c[15] ^ data[i];
                c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
            end
        end
        crc = c;
    end

endmodule

// File: rtl/phy_rx_lane_assembler.sv
// phy_rx_lane_assembler: gathers NLANES decoded 8b10b byte lanes into 32-bit
// flits framed by K_SOP / K_EOP beats and queues them in an output FIFO.
// Optional feature macro: PHY_RX_CRC_EN -- each flit is staged for one flit
// time; the flit in front of EOP is the CRC-16 word and is checked, not forwarded.
module phy_rx_lane_assembler
    import phy_types_pkg::*;
    import chiplet_types_pkg::*;
#(
    parameter int NLANES     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NLANES*8-1:0] lane_data,
    input  logic [NLANES-1:0]   lane_k,
    input  logic [NLANES-1:0]   lane_valid,
    input  logic [NLANES-1:0]   lane_err,
    output flit_t               flit,
    output logic                flit_valid,
    input  logic                flit_ready,
    output logic                packet_done,
    output logic                crc_corr,
    output logic                err_out
);
    localparam int BEATS = 4 / NLANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

    rx_state_t        state, state_next;
    logic [CNT_W-1:0] beat_cnt;
    flit_t            asm_q, asm_flit, push_data;
    logic             all_valid, skew, all_k, no_k, is_sop, is_eop, last_beat;
    logic             store, complete, end_pkt, proto_err;
    logic             push_req, overflow, push_ok, pop, err_evt, eop_allowed, crc_ok;

    flit_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;

    // Classify the lane beat and build the flit it would complete at the current beat slot.
    always_comb begin
        all_valid = &lane_valid;
        skew      = (|lane_valid) && !all_valid;
        all_k     = &lane_k;
        no_k      = ~|lane_k;
        is_sop    = all_valid && all_k;
        is_eop    = all_valid && all_k;
        for (int l = 0; l < NLANES; l++) begin
            is_sop = is_sop && (lane_data[l*8 +: 8] == K_SOP);
            is_eop = is_eop && (lane_data[l*8 +: 8] == K_EOP);
        end
        asm_flit = asm_q;
        for (int b = 0; b < 4; b++) begin
            if (CNT_W'(b / NLANES) == beat_cnt)
                asm_flit[b*8 +: 8] = lane_data[(b % NLANES)*8 +: 8];
        end
        last_beat = (beat_cnt == CNT_W'(BEATS - 1));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state: errors win over EOP; DROP waits for EOP and ignores SOP.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (is_sop) state_next = ASSM;
            ASSM: begin
                if (err_evt)      state_next = DROP;
                else if (end_pkt) state_next = IDLE;
            end
            DROP:    if (is_eop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: what the current beat means for the packet being assembled.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the block can infer a latch.
        store     = 1'b0;
        complete  = 1'b0;
        end_pkt   = 1'b0;
        proto_err = 1'b0;
        if (state == ASSM) begin
            if (skew || (|lane_err)) begin
                proto_err = 1'b1;
            end else if (all_valid) begin
                if (no_k) begin
                    store    = 1'b1;
                    complete = last_beat;
                end else if (is_eop && beat_cnt == '0 && eop_allowed) begin
                    end_pkt = 1'b1;
                end else begin
                    proto_err = 1'b1;
                end
            end
        end
    end

    // FIFO handshake: a full FIFO still accepts a push when the head leaves the same cycle.
    always_comb begin
        pop      = flit_valid && flit_ready;
        overflow = push_req && (count == FULL_CNT) && !pop;
        push_ok  = push_req && !overflow;
        err_evt  = proto_err || overflow;
    end

`ifdef PHY_RX_CRC_EN
    flit_t       staged;
    logic        staged_valid, crc_first;
    logic [15:0] crc_acc;
    logic [15:0] crc_link [5];

    assign push_req    = complete && staged_valid;
    assign push_data   = staged;
    assign eop_allowed = staged_valid;
    assign crc_ok      = (staged[15:0] == (crc_first ? CRC_INIT : crc_acc));
    assign crc_link[0] = crc_acc;

    for (genvar b = 0; b < 4; b++) begin : g_crc
        phy_rx_crc16 u_crc (
            .init   (crc_first && (b == 0)),
            .en     (push_ok),
            .data   (staged[b*8 +: 8]),
            .crc_in (crc_link[b]),
            .crc    (crc_link[b+1])
        );
    end

    // Stage each completed flit; fold a flit into the CRC only once it is actually forwarded.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            staged       <= '0;
            staged_valid <= 1'b0;
            crc_first    <= 1'b1;
            crc_acc      <= CRC_INIT;
        end else if (state == IDLE && is_sop) begin
            staged_valid <= 1'b0;
            crc_first    <= 1'b1;
        end else if (complete) begin
            staged       <= asm_flit;
            staged_valid <= 1'b1;
            if (push_ok) begin
                crc_acc   <= crc_link[4];
                crc_first <= 1'b0;
            end
        end
    end
`else
    assign push_req    = complete;
    assign push_data   = asm_flit;
    assign eop_allowed = 1'b1;
    assign crc_ok      = 1'b1;
`endif

    // Beat counter and partial-flit bytes; SOP or any error restarts at beat 0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            beat_cnt <= '0;
            asm_q    <= '0;
        end else if ((state == IDLE && is_sop) || err_evt) begin
            beat_cnt <= '0;
        end else if (store) begin
            asm_q    <= asm_flit;
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
    end

    // FIFO storage write.
    // NOTE: the storage array has no reset; flit is forced to 0 while empty, so stale entries never show.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign flit_valid = (count != '0);
    assign flit       = flit_valid ? mem[rd_ptr] : '0;

    // Registered status pulses, one cycle after the beat that caused them.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            packet_done <= 1'b0;
            crc_corr    <= 1'b0;
            err_out     <= 1'b0;
        end else begin
            packet_done <= end_pkt;
            crc_corr    <= end_pkt && crc_ok;
            err_out     <= err_evt;
        end
    end

endmodule

// File: tb/tb_phy_rx_lane_assembler.sv
// tb_phy_rx_lane_assembler: table vectors, directed corner sequences and
// randomized beats checked against a queue-based packet model.
`timescale 1ns/1ps
module tb_phy_rx_lane_assembler;

`ifdef PHY_RX_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;

    // DUT A: NLANES=2
    logic [15:0] a_data = '0;
    logic [1:0]  a_k = '0, a_v = '0, a_e = '0;
    logic        a_rdy = 1'b0;
    logic [31:0] a_flit;
    logic        a_fv, a_done, a_corr, a_err;

    // DUT B: NLANES=4
    logic [31:0] b_data = '0;
    logic [3:0]  b_k = '0, b_v = '0, b_e = '0;
    logic        b_rdy = 1'b0;
    logic [31:0] b_flit;
    logic        b_fv, b_done, b_corr, b_err;

    int total = 0;
    int bad   = 0;

    phy_rx_lane_assembler #(.NLANES(2), .FIFO_DEPTH(DEPTH)) u_dut_a (
        .clk(clk), .n_rst(n_rst), .lane_data(a_data), .lane_k(a_k), .lane_valid(a_v),
        .lane_err(a_e), .flit(a_flit), .flit_valid(a_fv), .flit_ready(a_rdy),
        .packet_done(a_done), .crc_corr(a_corr), .err_out(a_err)
    );

    phy_rx_lane_assembler #(.NLANES(4), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .lane_data(b_data), .lane_k(b_k), .lane_valid(b_v),
        .lane_err(b_e), .flit(b_flit), .flit_valid(b_fv), .flit_ready(b_rdy),
        .packet_done(b_done), .crc_corr(b_corr), .err_out(b_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (DUT A, two lanes) ----------------
    int          m_mode;          // 0 waiting for SOP, 1 in packet, 2 discarding to EOP
    logic [7:0]  m_part[$];       // bytes of the flit being gathered
    logic [31:0] m_fifo[$];
    logic [31:0] m_staged[$];
    logic [7:0]  m_pushed[$];     // every byte forwarded in this packet
    logic [31:0] e_flit;
    logic        e_fv, e_done, e_corr, e_err;

    function automatic logic [15:0] ref_crc(input logic [7:0] q[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (q[i]) begin
            c = c ^ {q[i], 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_part.delete(); m_fifo.delete(); m_staged.delete(); m_pushed.delete();
        e_flit = '0; e_fv = 0; e_done = 0; e_corr = 0; e_err = 0;
    endtask

    task automatic model_step(input logic [1:0] v, k, e, input logic [15:0] d, input logic rdy);
        logic [7:0]  b0, b1;
        logic [31:0] fl, out;
        bit all_v, skew, sop, eop, pop, err, done, ok;
        b0    = d[7:0];
        b1    = d[15:8];
        all_v = (v == 2'b11);
        skew  = (v != 2'b00) && !all_v;
        sop   = all_v && k == 2'b11 && b0 == 8'hBC && b1 == 8'hBC;
        eop   = all_v && k == 2'b11 && b0 == 8'h3C && b1 == 8'h3C;
        pop   = (m_fifo.size() != 0) && rdy;
        err = 0; done = 0; ok = 0;
        if (m_mode == 0) begin
            if (sop) begin
                m_mode = 1;
                m_part.delete(); m_staged.delete(); m_pushed.delete();
            end
        end else if (m_mode == 1) begin
            if (skew || e != 2'b00) err = 1;
            else if (all_v) begin
                if (k == 2'b00) begin
                    m_part.push_back(b0);
                    m_part.push_back(b1);
                    if (m_part.size() == 4) begin
                        fl = {m_part[3], m_part[2], m_part[1], m_part[0]};
                        m_part.delete();
                        if (CRC_EN && m_staged.size() == 0) m_staged.push_back(fl);
                        else begin
                            if (CRC_EN) out = m_staged.pop_front();
                            else        out = fl;
                            if (m_fifo.size() == DEPTH && !pop) err = 1;
                            else begin
                                m_fifo.push_back(out);
                                for (int i = 0; i < 4; i++) m_pushed.push_back(out[i*8 +: 8]);
                            end
                            if (CRC_EN) m_staged.push_back(fl);
                        end
                    end
                end else if (eop && m_part.size() == 0 && (!CRC_EN || m_staged.size() != 0)) begin
                    done = 1;
                    ok   = CRC_EN ? (ref_crc(m_pushed) == m_staged[0][15:0]) : 1'b1;
                    m_mode = 0;
                end else err = 1;
            end
            if (err) begin
                m_mode = 2;
                m_part.delete();
            end
        end else begin
            if (eop) m_mode = 0;
        end
        if (pop) void'(m_fifo.pop_front());
        e_fv   = (m_fifo.size() != 0);
        e_flit = e_fv ? m_fifo[0] : 32'h0;
        e_done = done;
        e_corr = done && ok;
        e_err  = err;
    endtask

    // One DUT A cycle: drive at the falling edge, clock, compare at the next falling edge.
    task automatic cyc_a(input logic [1:0] v, k, e, input logic [15:0] d, input logic rdy);
        a_v = v; a_k = k; a_e = e; a_data = d; a_rdy = rdy;
        model_step(v, k, e, d, rdy);
        @(negedge clk);
        check("a_flit", a_flit, e_flit);
        check("a_ctl{fv,done,corr,err}", {28'h0, a_fv, a_done, a_corr, a_err},
              {28'h0, e_fv, e_done, e_corr, e_err});
    endtask

    task automatic a_sop(input logic rdy);                     cyc_a(2'b11, 2'b11, 2'b00, 16'hBCBC, rdy); endtask
    task automatic a_eop(input logic rdy);                     cyc_a(2'b11, 2'b11, 2'b00, 16'h3C3C, rdy); endtask
    task automatic a_dat(input logic [15:0] d, input logic rdy); cyc_a(2'b11, 2'b00, 2'b00, d, rdy);        endtask
    task automatic a_idle(input logic rdy);                    cyc_a(2'b00, 2'b00, 2'b00, 16'h0000, rdy); endtask

    task automatic cyc_b(input logic [3:0] v, k, input logic [31:0] d, input logic rdy);
        b_v = v; b_k = k; b_e = 4'h0; b_data = d; b_rdy = rdy;
        @(negedge clk);
    endtask

    typedef struct {
        logic [1:0]  v, k, e;
        logic [15:0] d;
        logic        rdy;
        logic [31:0] flit;
        logic        fv, done, corr, err;
    } vec_t;

    vec_t        tbl[7];
    logic [7:0]  cq[$];
    logic [15:0] crc;
    logic [1:0]  rv, rk, re;
    logic [15:0] rd;
    int          r;

    initial begin
        // Packet 01..08 on two lanes, consumer stalled until EOP (no-CRC expectations).
        tbl[0] = '{2'b11, 2'b11, 2'b00, 16'hBCBC, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{2'b11, 2'b00, 2'b00, 16'h0201, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{2'b11, 2'b00, 2'b00, 16'h0403, 1'b0, 32'h04030201, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{2'b11, 2'b00, 2'b00, 16'h0605, 1'b0, 32'h04030201, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{2'b11, 2'b00, 2'b00, 16'h0807, 1'b0, 32'h04030201, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{2'b11, 2'b11, 2'b00, 16'h3C3C, 1'b1, 32'h08070605, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{2'b00, 2'b00, 2'b00, 16'h0000, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        check("reset a_flit", a_flit, 32'h0);
        check("reset a_ctl", {28'h0, a_fv, a_done, a_corr, a_err}, 32'h0);
        check("reset b_ctl", {28'h0, b_fv, b_done, b_corr, b_err}, 32'h0);
        n_rst = 1'b1;
        @(negedge clk);

        // Table vectors: two flits on two lanes, then EOP.
        for (int i = 0; i < 7; i++) begin
            cyc_a(tbl[i].v, tbl[i].k, tbl[i].e, tbl[i].d, tbl[i].rdy);
`ifndef PHY_RX_CRC_EN
            check($sformatf("tbl[%0d] flit", i), a_flit, tbl[i].flit);
            check($sformatf("tbl[%0d] ctl", i), {28'h0, a_fv, a_done, a_corr, a_err},
                  {28'h0, tbl[i].fv, tbl[i].done, tbl[i].corr, tbl[i].err});
`endif
        end

        // Four lanes: one flit per beat.
        cyc_b(4'hF, 4'hF, 32'hBCBCBCBC, 1'b0);
        cyc_b(4'hF, 4'h0, 32'h44332211, 1'b0);
`ifdef PHY_RX_CRC_EN
        check("b staged not forwarded", {31'h0, b_fv}, 32'h0);
        cq.delete();
        cq.push_back(8'h11); cq.push_back(8'h22); cq.push_back(8'h33); cq.push_back(8'h44);
        crc = ref_crc(cq);
        cyc_b(4'hF, 4'h0, {16'h0000, crc}, 1'b0);
        check("b flit", b_flit, 32'h44332211);
        check("b fv", {31'h0, b_fv}, 32'h1);
        cyc_b(4'hF, 4'hF, 32'h3C3C3C3C, 1'b1);
        check("b good crc {done,corr,err}", {29'h0, b_done, b_corr, b_err}, 32'h6);
        check("b one flit only", {31'h0, b_fv}, 32'h0);
        cyc_b(4'hF, 4'hF, 32'hBCBCBCBC, 1'b1);
        cyc_b(4'hF, 4'h0, 32'h44332211, 1'b1);
        cyc_b(4'hF, 4'h0, {16'h0000, crc ^ 16'h0001}, 1'b1);
        cyc_b(4'hF, 4'hF, 32'h3C3C3C3C, 1'b1);
        check("b bad crc {done,corr,err}", {29'h0, b_done, b_corr, b_err}, 32'h4);
`else
        check("b flit", b_flit, 32'h44332211);
        check("b fv", {31'h0, b_fv}, 32'h1);
        cyc_b(4'hF, 4'hF, 32'h3C3C3C3C, 1'b1);
        check("b eop {done,corr,err}", {29'h0, b_done, b_corr, b_err}, 32'h6);
        check("b drained", {31'h0, b_fv}, 32'h0);
`endif
        cyc_b(4'h0, 4'h0, 32'h0, 1'b1);

        // lane_err on lane 1 mid-flit, rest ignored until EOP, next packet accepted.
        a_sop(1'b1);
        a_dat(16'h0201, 1'b1);
        cyc_a(2'b11, 2'b00, 2'b10, 16'h0403, 1'b1);
        check("lane_err err_out", {31'h0, a_err}, 32'h1);
        check("lane_err no partial", {31'h0, a_fv}, 32'h0);
        a_dat(16'h0605, 1'b1);
        a_sop(1'b1);
        a_dat(16'h0807, 1'b1);
        check("drop ignores beats", {30'h0, a_fv, a_err}, 32'h0);
        a_eop(1'b1);
        a_sop(1'b0);
        a_dat(16'h0A09, 1'b0);
        a_dat(16'h0C0B, 1'b0);
`ifndef PHY_RX_CRC_EN
        check("next packet flit", a_flit, 32'h0C0B0A09);
`endif
        a_eop(1'b1);
        a_idle(1'b1);

        // Overflow: five flits into a four-deep FIFO with the consumer stalled.
        a_sop(1'b0);
        for (int i = 0; i < 10; i++) a_dat({8'h21 + 8'(2*i), 8'h20 + 8'(2*i)}, 1'b0);
`ifndef PHY_RX_CRC_EN
        check("overflow err_out", {31'h0, a_err}, 32'h1);
        check("overflow head kept", a_flit, 32'h23222120);
`endif
        a_sop(1'b0);
        a_dat(16'h7170, 1'b0);
        a_dat(16'h7372, 1'b0);
        check("drop after overflow quiet", {31'h0, a_err}, 32'h0);
        for (int i = 0; i < 5; i++) a_idle(1'b1);
        check("fifo drained, nothing from DROP", {31'h0, a_fv}, 32'h0);
        a_eop(1'b1);

        // Skew in ASSM, then EOP at beat 1.
        a_sop(1'b1);
        cyc_a(2'b01, 2'b00, 2'b00, 16'h0055, 1'b1);
        check("skew err_out", {31'h0, a_err}, 32'h1);
        a_eop(1'b1);
        a_sop(1'b1);
        a_dat(16'h0201, 1'b1);
        a_eop(1'b1);
        check("eop beat1 {done,err}", {30'h0, a_done, a_err}, 32'h1);
        a_eop(1'b1);

        // Reset mid-packet with a flit waiting in the FIFO.
        a_sop(1'b0);
        a_dat(16'h0201, 1'b0);
        a_dat(16'h0403, 1'b0);
        a_dat(16'h0605, 1'b0);
        #2 n_rst = 1'b0;
        a_v = 2'b00; a_k = 2'b00; a_e = 2'b00; a_data = '0;
        #1;
        check("mid reset flit", a_flit, 32'h0);
        check("mid reset ctl", {28'h0, a_fv, a_done, a_corr, a_err}, 32'h0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        a_dat(16'h0807, 1'b1);
        a_dat(16'h0A09, 1'b1);
        a_dat(16'h0C0B, 1'b1);
        a_eop(1'b1);
        check("no SOP after reset {fv,done}", {30'h0, a_fv, a_done}, 32'h0);

        // Randomized beats against the model.
        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 99);
            rv = 2'b11; rk = 2'b00; re = 2'b00;
            rd = 16'($urandom);
            if (r < 8)       begin rk = 2'b11; rd = 16'hBCBC; end
            else if (r < 16) begin rk = 2'b11; rd = 16'h3C3C; end
            else if (r < 70) begin end
            else if (r < 76) rv = 2'b00;
            else if (r < 80) re = 2'($urandom_range(1, 3));
            else if (r < 84) rv = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            else if (r < 88) rk = 2'($urandom_range(1, 3));
            else             rv = 2'b00;
            cyc_a(rv, rk, re, rd, ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
